// File: rtl/matvec_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : matvec_scheduler_if
// Brief  : x stream, weight memory, dot-product and y stream bundle
// Rev    : 1.0
// ============================================================================
interface matvec_scheduler_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int ROW_WIDTH  = 2
);
    logic                    x_valid;
    logic                    x_ready;
    logic [N*DATA_WIDTH-1:0] x_data;
    logic                    w_rd_en;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [N*DATA_WIDTH-1:0] w_rdata;
    logic [N*DATA_WIDTH-1:0] dp_x;
    logic [N*DATA_WIDTH-1:0] dp_w;
    logic [ACC_WIDTH-1:0]    dp_result;
    logic                    y_valid;
    logic                    y_ready;
    logic [ACC_WIDTH-1:0]    y_data;
    logic [ROW_WIDTH-1:0]    y_row;

    modport master (
        input  x_valid, x_data, w_rdata, dp_result, y_ready,
        output x_ready, w_rd_en, w_addr, dp_x, dp_w, y_valid, y_data, y_row
    );

    modport slave (
        output x_valid, x_data, w_rdata, dp_result, y_ready,
        input  x_ready, w_rd_en, w_addr, dp_x, dp_w, y_valid, y_data, y_row
    );
endinterface

`default_nettype wire

// File: rtl/matvec_scheduler.sv
`default_nettype none
// ============================================================================
// Module : matvec_scheduler
// Brief  : Tiles y = W*x over a shared N-lane dot-product unit
// Rev    : 1.0
// ============================================================================
module matvec_scheduler #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ROWS       = 4,
    parameter int TILES      = 2,
    parameter int ADDR_WIDTH = (ROWS * TILES > 1) ? $clog2(ROWS * TILES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    matvec_scheduler_if.master bus
);
    localparam int c_TILE_W = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int c_ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [c_TILE_W-1:0] c_LAST_TILE = c_TILE_W'(TILES - 1);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_TILE_W-1:0]     r_tile;
    logic [c_ROW_W-1:0]      r_row;
    logic                    r_rd_valid;
    logic [c_TILE_W-1:0]     r_rd_tile;
    logic                    r_rd_last;
    logic [ACC_WIDTH-1:0]    r_acc;
    logic [ACC_WIDTH-1:0]    r_y_data;
    logic [c_ROW_W-1:0]      r_y_row;
    logic                    r_y_valid;
    logic                    r_done;
    logic [N*DATA_WIDTH-1:0] r_xbuf [TILES];

    logic                    w_busy;
    logic                    w_x_ready;
    logic                    w_rd_en;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_last_tile;
    logic                    w_x_hs;
    logic                    w_y_hs;
    logic [ACC_WIDTH-1:0]    w_acc_sum;

    assign w_last_tile = (r_tile == c_LAST_TILE);
    assign w_x_hs      = w_x_ready && bus.x_valid;
    assign w_y_hs      = (r_state == S_OUT) && r_y_valid && bus.y_ready;
    // The first tile of a row restarts the sum, so no explicit clear is needed.
    assign w_acc_sum   = (r_rd_tile == '0) ? bus.dp_result : r_acc + bus.dp_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_x_ready   = 1'b0;
        w_rd_en     = 1'b0;
        w_addr      = '0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) w_state_nxt = S_LOAD_X;
            end
            S_LOAD_X: begin
                w_x_ready = 1'b1;
                if (bus.x_valid && w_last_tile) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_rd_en = 1'b1;
                w_addr  = ADDR_WIDTH'(int'(r_row) * TILES + int'(r_tile));
                if (w_last_tile) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_OUT;
            S_OUT: begin
                if (bus.y_ready) w_state_nxt = (r_row == c_LAST_ROW) ? S_IDLE : S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tile     <= '0;
            r_row      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_tile  <= '0;
            r_rd_last  <= 1'b0;
            r_acc      <= '0;
            r_y_data   <= '0;
            r_y_row    <= '0;
            r_y_valid  <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < TILES; i++) r_xbuf[i] <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_tile <= r_tile;
                r_rd_last <= w_last_tile;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tile <= '0;
                        r_row  <= '0;
                    end
                end
                S_LOAD_X: begin
                    if (w_x_hs) begin
                        r_xbuf[r_tile] <= bus.x_data;
                        r_tile         <= w_last_tile ? '0 : r_tile + 1'b1;
                    end
                end
                S_RUN: r_tile <= w_last_tile ? '0 : r_tile + 1'b1;
                S_OUT: begin
                    if (w_y_hs) begin
                        r_y_valid <= 1'b0;
                        if (r_row == c_LAST_ROW) begin
                            r_done <= 1'b1;
                        end else begin
                            r_row  <= r_row + 1'b1;
                            r_tile <= '0;
                        end
                    end
                end
                default: ;
            endcase
            // Weight data lands one cycle after the read strobe.
            if (r_rd_valid) begin
                r_acc <= w_acc_sum;
                if (r_rd_last) begin
                    r_y_data  <= w_acc_sum;
                    r_y_row   <= r_row;
                    r_y_valid <= 1'b1;
                end
            end
        end
    end

    assign busy        = w_busy;
    assign done        = r_done;
    assign bus.x_ready = w_x_ready;
    assign bus.w_rd_en = w_rd_en;
    assign bus.w_addr  = w_addr;
    assign bus.dp_x    = r_rd_valid ? r_xbuf[r_rd_tile] : '0;
    assign bus.dp_w    = r_rd_valid ? bus.w_rdata : '0;
    assign bus.y_valid = r_y_valid;
    assign bus.y_data  = r_y_data;
    assign bus.y_row   = r_y_row;

endmodule

`default_nettype wire

// File: tb/tb_matvec_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_matvec_scheduler
// Brief  : Directed scoreboard bench for matvec_scheduler
// Rev    : 1.0
// ============================================================================
module tb_matvec_scheduler;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int AW    = 32;
    localparam int ROWS  = 4;
    localparam int TILES = 2;
    localparam int ADDRW = 3;
    localparam int ROWW  = 2;

    typedef struct packed {
        logic [ROWW-1:0] row;
        logic [AW-1:0]   data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    matvec_scheduler_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
                          .ADDR_WIDTH(ADDRW), .ROW_WIDTH(ROWW)) bus ();

    matvec_scheduler #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(ROWS),
                       .TILES(TILES), .ADDR_WIDTH(ADDRW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [N*DW-1:0] wmem [ROWS*TILES];
    logic [N*DW-1:0] xt   [TILES];
    exp_t            exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;
    int done_cnt = 0;
    int n_jobs   = 0;
    int exp_addr = 0;
    int rd_in_row = 0;
    bit prev_yv  = 1'b0;
    logic signed [AW-1:0] dp_sum;

    // Synchronous weight SRAM and combinational dot-product unit around the DUT.
    always @(posedge clk) if (bus.w_rd_en) bus.w_rdata <= wmem[bus.w_addr];

    always_comb begin
        dp_sum = '0;
        for (int i = 0; i < N; i++)
            dp_sum = dp_sum + int'($signed(bus.dp_x[i*DW +: DW])) * int'($signed(bus.dp_w[i*DW +: DW]));
        bus.dp_result = dp_sum;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [N*DW-1:0] splat(input int v);
        logic [N*DW-1:0] t;
        for (int i = 0; i < N; i++) t[i*DW +: DW] = DW'(v);
        return t;
    endfunction

    task automatic push_expected();
        for (int r = 0; r < ROWS; r++) begin
            int s;
            s = 0;
            for (int t = 0; t < TILES; t++)
                for (int i = 0; i < N; i++)
                    s += int'($signed(xt[t][i*DW +: DW])) * int'($signed(wmem[r*TILES+t][i*DW +: DW]));
            exp_q.push_back('{row: ROWW'(r), data: AW'(s)});
        end
    endtask

    // Address order, read-strobe placement and result scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_yv = 1'b0;
        end else begin
            if (bus.x_ready) begin
                exp_addr  = 0;
                rd_in_row = 0;
            end
            if (bus.x_ready || bus.y_valid) check("rd_en_quiet", bus.w_rd_en, 0);
            if (bus.w_rd_en) begin
                check("w_addr", bus.w_addr, exp_addr);
                exp_addr++;
                rd_in_row++;
            end
            if (bus.y_valid && !prev_yv) begin
                check("rd_per_row", rd_in_row, TILES);
                rd_in_row = 0;
            end
            if (bus.y_valid && bus.y_ready) begin
                check("y_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("y_data", bus.y_data, e.data);
                    check("y_row", bus.y_row, e.row);
                end
            end
            if (done) done_cnt++;
            prev_yv = bus.y_valid;
        end
    end

    task automatic start_job();
        push_expected();
        start_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_x_ready", bus.x_ready, 1);
    endtask

    task automatic feed_x(input int gap);
        for (int b = 0; b < TILES; b++) begin
            for (int g = 0; g < gap; g++) begin
                bus.x_valid = 1'b0;
                bus.x_data  = $urandom;
                check("x_wait_ready", bus.x_ready, 1);
                tick();
            end
            bus.x_valid = 1'b1;
            bus.x_data  = xt[b];
            check("x_ready", bus.x_ready, 1);
            tick();
        end
        bus.x_valid = 1'b0;
        bus.x_data  = $urandom;
        check("run_x_ready", bus.x_ready, 0);
    endtask

    task automatic drain(input int stall_row, input int stall_len, input bit poke, input bit chk_lat);
        int stalled, d0;
        bit was_stalled, poked, seen_yv, chk_issue;
        stalled = 0; was_stalled = 0; poked = 0; seen_yv = 0; chk_issue = 0;
        d0 = done_cnt;
        n_jobs++;
        for (int n = 0; n < 300; n++) begin
            if (chk_issue) begin
                check("issue_en", bus.w_rd_en, 1);
                check("issue_addr", bus.w_addr, (stall_row + 1) * TILES);
                chk_issue = 0;
            end
            if (done) break;
            start = poke && !poked && bus.w_rd_en;
            if (start) poked = 1;
            if (chk_lat && bus.y_valid && !seen_yv) check("first_y_cycle", cyc - start_cyc, 2*TILES+2);
            if (bus.y_valid) seen_yv = 1;
            if (bus.y_valid && int'(bus.y_row) == stall_row && stalled < stall_len) begin
                bus.y_ready = 1'b0;
                stalled++;
                was_stalled = 1;
                if (exp_q.size() != 0) check("stall_y_data", bus.y_data, exp_q[0].data);
                check("stall_rd_en", bus.w_rd_en, 0);
            end else begin
                bus.y_ready = 1'b1;
                if (was_stalled && bus.y_valid) begin
                    was_stalled = 0;
                    chk_issue   = (stall_row < ROWS - 1);
                end
            end
            tick();
        end
        start = 1'b0;
        check("done_pulse", done, 1);
        check("no_early_done", done_cnt - d0, 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic after_done();
        tick();
        check("done_once", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        bus.x_valid = 1'b0; bus.x_data = '0; bus.y_ready = 1'b0;
        for (int t = 0; t < TILES; t++)
            for (int i = 0; i < N; i++) xt[t][i*DW +: DW] = DW'(t*N + i + 1);
        for (int r = 0; r < ROWS; r++)
            for (int t = 0; t < TILES; t++) wmem[r*TILES+t] = splat(r + 1);
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x_ready", bus.x_ready, 0);
        check("rst_w_rd_en", bus.w_rd_en, 0);
        check("rst_w_addr", bus.w_addr, 0);
        check("rst_y_valid", bus.y_valid, 0);
        check("rst_y_data", bus.y_data, 0);
        check("rst_y_row", bus.y_row, 0);
        check("rst_dp_x", bus.dp_x, 0);
        rst = 1'b0;
        tick(); tick();
        check("idle_busy0", busy, 0);

        // Basic job with latency and address-order checks.
        start_job(); feed_x(0); drain(-1, 0, 0, 1); after_done();

        // Signed extremes.
        for (int t = 0; t < TILES; t++) xt[t] = splat(-128);
        for (int k = 0; k < ROWS*TILES; k++) wmem[k] = splat(-128);
        tick();
        start_job(); feed_x(0); drain(-1, 0, 0, 1); after_done();
        for (int t = 0; t < TILES; t++) xt[t] = splat(127);
        start_job(); feed_x(0); drain(-1, 0, 0, 0); after_done();

        // Backpressure on row 1 and gapped x beats.
        for (int t = 0; t < TILES; t++)
            for (int i = 0; i < N; i++) xt[t][i*DW +: DW] = DW'(t*N + i + 1);
        for (int r = 0; r < ROWS; r++)
            for (int t = 0; t < TILES; t++) wmem[r*TILES+t] = splat(r + 1);
        start_job(); feed_x(2); drain(1, 3, 0, 0); after_done();

        // Stray start during RUN, then a back-to-back job started in the done cycle.
        start_job(); feed_x(0); drain(-1, 0, 1, 0);
        for (int t = 0; t < TILES; t++) xt[t] = $urandom;
        for (int k = 0; k < ROWS*TILES; k++) wmem[k] = $urandom;
        start_job();
        check("b2b_done_clear", done, 0);
        feed_x(0); drain(-1, 0, 0, 0); after_done();

        // Reset in the middle of row 2.
        start_job(); feed_x(0);
        bus.y_ready = 1'b1;
        for (int n = 0; n < 100 && !(bus.w_rd_en && bus.w_addr == 3'd4); n++) tick();
        check("reached_row2", bus.w_addr, 4);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_w_rd_en", bus.w_rd_en, 0);
        check("mid_rst_w_addr", bus.w_addr, 0);
        check("mid_rst_y_valid", bus.y_valid, 0);
        check("mid_rst_y_data", bus.y_data, 0);
        check("mid_rst_y_row", bus.y_row, 0);
        check("mid_rst_dp_x", bus.dp_x, 0);
        check("mid_rst_dp_w", bus.dp_w, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);
        for (int t = 0; t < TILES; t++) xt[t] = $urandom;
        start_job(); feed_x(1); drain(2, 2, 0, 0); after_done();

        check("done_total", done_cnt, n_jobs);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/matvec_scheduler.md
Name: matvec_scheduler

Overview:
- Sequences one shared dot-product datapath (N lanes, signed, combinational) to compute y = W·x.
- W is ROWS x (TILES*N); x is TILES*N elements.
- Loads x once into an internal tile buffer, streams weight tiles from an external synchronous weight memory, and accumulates per-tile partial dot products into one result per row.
- Sits between the NPU command/stream logic and the dot-product unit plus weight SRAM.

Parameters:
N, 4, elements per tile (lanes of the dot-product unit)
DATA_WIDTH, 8, signed element width
ACC_WIDTH, 32, signed accumulator/result width
ROWS, 4, matrix rows (outputs per job)
TILES, 2, tiles per row; row length = TILES*N
ADDR_WIDTH, $clog2(ROWS*TILES) (min 1), weight memory address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin job; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after final row handshake
x_valid  in  1  x tile beat valid
x_ready  out  1  high only in LOAD_X
x_data  in  N*DATA_WIDTH  packed x tile, element i at [i*DATA_WIDTH +: DATA_WIDTH]
w_rd_en  out  1  weight read strobe
w_addr  out  ADDR_WIDTH  weight tile address = row*TILES + tile
w_rdata  in  N*DATA_WIDTH  weight tile, valid the cycle after w_rd_en
dp_x  out  N*DATA_WIDTH  x operand to dot-product unit
dp_w  out  N*DATA_WIDTH  weight operand to dot-product unit
dp_result  in  ACC_WIDTH  combinational dot product of dp_x, dp_w
y_valid  out  1  result valid
y_ready  in  1  result accepted
y_data  out  ACC_WIDTH  row result
y_row  out  $clog2(ROWS) (min 1)  row index of y_data

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, x_ready, w_rd_en, y_valid, w_addr, y_data, y_row, accumulator, tile/row counters and x buffer all 0. The read pipeline valid bit is cleared.
- FSM states:
  - IDLE: start=1 -> LOAD_X with tile=0, row=0.
  - LOAD_X: x_ready=1. Each x_valid&&x_ready writes x_buf[tile] and increments tile. The beat at tile=TILES-1 -> RUN with tile=0.
  - RUN: w_rd_en=1, w_addr=row*TILES+tile, one tile per cycle with no gaps. Issuing tile TILES-1 -> DRAIN.
  - DRAIN: single cycle; the last read returns. -> OUT.
  - OUT: y_valid=1, data held stable. On y_ready: y_valid<=0. If row==ROWS-1 -> IDLE, with done=1 in the following cycle. Otherwise row++, tile=0 -> RUN.
- Read pipeline:
  - One register stage (rd_valid, rd_tile, rd_last) follows each w_rd_en.
  - While rd_valid: dp_x=x_buf[rd_tile] and dp_w=w_rdata; otherwise both are 0.
  - At the edge where rd_valid: acc <= (rd_tile==0) ? dp_result : acc+dp_result.
  - If rd_last also: y_data <= acc+dp_result (or dp_result when TILES=1), y_row <= row, y_valid <= 1.
- Arithmetic: signed two's-complement, wraps modulo 2^ACC_WIDTH. No saturation.
- Latency (x_valid and y_ready held high):
  - Start sampled in cycle 0; LOAD_X occupies cycles 1..TILES.
  - First y_valid in cycle 2*TILES+2.
  - Each further row costs TILES+2 cycles.
- Boundary conditions:
  - start while busy: ignored.
  - x_valid low in LOAD_X: wait indefinitely.
  - y_ready low in OUT: stall. No w_rd_en, y_data/y_row stable.
  - x_data sampled only on a handshake.
  - TILES=1: RUN lasts one cycle.
  - done and start in the same cycle: done is already in IDLE, so the start is accepted.

Test Plan:
1. Basic: N=4, DATA_WIDTH=8, TILES=2, ROWS=4. x=[1,2,3,4 | 5,6,7,8]; every weight element of row r = r+1; y_ready=1 -> y_data 36,72,108,144 on y_row 0..3. First y_valid in cycle 6 after start. done pulses once.
2. Address order: check the w_addr sequence 0,1,2,3,4,5,6,7, with w_rd_en exactly 2 cycles per row and none in LOAD_X/DRAIN/OUT.
3. Signed extremes: all x and w = -128 -> every y_data = 131072. Then x=127, w=-128 -> every y_data = -130048.
4. Backpressure: hold y_ready=0 for 3 cycles on row 1 -> y_valid stays 1, y_data=72 stable, w_rd_en=0. Row 2 issues the cycle after acceptance. x_valid gaps of 2 cycles in LOAD_X -> same results.
5. start pulsed during RUN -> ignored, exactly 4 results. Back-to-back job: start in the done cycle -> second job runs with fresh x.
6. Assert rst during row 2 RUN -> all outputs 0 immediately, busy=0, no done. A new job after reset gives correct results.
